// File: rtl/dac_spi_rx.sv
// -----------------------------------------------------------------------------
// dac_spi_rx
// Receiving end of the DAC command link. Samples the three DAC SPI pins in the
// clk domain, reassembles 16-bit MSB-first frames and decodes them into
// channel / config / value fields.
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   cs_pin_i       chip select pin, active low
//   clk_pin_i      serial clock pin (data taken on its rising edge)
//   data_pin_i     serial data pin
//   strobe_o       one-cycle pulse: valid frame committed
//   axis_o         channel of the last valid frame (0=A, 1=B)
//   config_o       {buffered, gain, shutdown_n} of the last valid frame
//   value_o        value of the last valid frame
//   value_a_o      last committed value for channel A
//   value_b_o      last committed value for channel B
//   frame_error_o  one-cycle pulse: frame rejected
//   error_count_o  saturating count of rejected frames
// -----------------------------------------------------------------------------
module dac_spi_rx #(
    parameter bit         CHECK_CONFIG  = 1'b1,
    parameter logic [2:0] EXPECT_CONFIG = 3'b111
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cs_pin_i,
    input  logic        clk_pin_i,
    input  logic        data_pin_i,
    output logic        strobe_o,
    output logic        axis_o,
    output logic [2:0]  config_o,
    output logic [11:0] value_o,
    output logic [11:0] value_a_o,
    output logic [11:0] value_b_o,
    output logic        frame_error_o,
    output logic [7:0]  error_count_o
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    localparam logic [4:0] BITS_FRAME = 5'd16;
    localparam logic [4:0] BITS_SAT   = 5'd17;

    // Saturating 8-bit increment for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Input synchronizers and edge-history flops.
    logic cs_s1_q, cs_s2_q, cs_hist_q;
    logic sck_s1_q, sck_s2_q, sck_hist_q;
    logic dat_s1_q, dat_s2_q;

    // flushed_q marks that the synchronizer no longer holds reset values;
    // armed_q is set once cs has really been sampled high after reset, so the
    // artificial 1->0 transition seen when reset releases with cs low is not
    // mistaken for the start of a frame.
    logic flushed_q;
    logic armed_q;

    logic [0:0]  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [15:0] shift_q, shift_d;

    logic        strobe_q, strobe_d;
    logic        frame_error_q, frame_error_d;
    logic        axis_q, axis_d;
    logic [2:0]  config_q, config_d;
    logic [11:0] value_q, value_d;
    logic [11:0] value_a_q, value_a_d;
    logic [11:0] value_b_q, value_b_d;
    logic [7:0]  error_count_q, error_count_d;

    logic cs_fall_s, cs_rise_s, sck_rise_s;
    logic cfg_ok_s;
    logic commit_s, reject_s;

    assign cs_fall_s  = armed_q & cs_hist_q & ~cs_s2_q;
    assign cs_rise_s  = ~cs_hist_q & cs_s2_q;
    assign sck_rise_s = sck_s2_q & ~sck_hist_q;

    // Config field of the frame currently held in the shift register.
    assign cfg_ok_s = (CHECK_CONFIG == 1'b0) || (shift_q[14:12] == EXPECT_CONFIG);

    // Frame-assembly FSM: next state, bit counter, shift register and verdict.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = shift_q;
        commit_s = 1'b0;
        reject_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cs_fall_s) begin
                    state_d = S_ACTIVE;
                    // A serial-clock rise coincident with CS fall is bit 0.
                    if (sck_rise_s) begin
                        count_d = 5'd1;
                        shift_d = {15'd0, dat_s2_q};
                    end else begin
                        count_d = 5'd0;
                        shift_d = 16'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACTIVE: begin
                // CS rise wins over a coincident serial-clock rise.
                if (cs_rise_s) begin
                    state_d = S_IDLE;
                    if ((count_q == BITS_FRAME) && cfg_ok_s) begin
                        commit_s = 1'b1;
                    end else begin
                        reject_s = 1'b1;
                    end
                end else if (sck_rise_s) begin
                    shift_d = {shift_q[14:0], dat_s2_q};
                    count_d = (count_q == BITS_SAT) ? count_q : (count_q + 5'd1);
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = 5'd0;
                shift_d = 16'd0;
            end
        endcase
    end

    // Output register next values: decode on commit, count on reject.
    always_comb begin
        strobe_d      = commit_s;
        frame_error_d = reject_s;
        axis_d        = axis_q;
        config_d      = config_q;
        value_d       = value_q;
        value_a_d     = value_a_q;
        value_b_d     = value_b_q;
        if (commit_s) begin
            axis_d   = shift_q[15];
            config_d = shift_q[14:12];
            value_d  = shift_q[11:0];
            if (shift_q[15]) begin
                value_b_d = shift_q[11:0];
            end else begin
                value_a_d = shift_q[11:0];
            end
        end else begin
            value_d = value_q;
        end
        if (reject_s) begin
            error_count_d = sat_inc8(error_count_q);
        end else begin
            error_count_d = error_count_q;
        end
    end

    // All state: synchronizers, FSM and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cs_s1_q       <= 1'b1;
            cs_s2_q       <= 1'b1;
            cs_hist_q     <= 1'b1;
            sck_s1_q      <= 1'b0;
            sck_s2_q      <= 1'b0;
            sck_hist_q    <= 1'b0;
            dat_s1_q      <= 1'b0;
            dat_s2_q      <= 1'b0;
            flushed_q     <= 1'b0;
            armed_q       <= 1'b0;
            state_q       <= S_IDLE;
            count_q       <= 5'd0;
            shift_q       <= 16'd0;
            strobe_q      <= 1'b0;
            frame_error_q <= 1'b0;
            axis_q        <= 1'b0;
            config_q      <= 3'd0;
            value_q       <= 12'd0;
            value_a_q     <= 12'd0;
            value_b_q     <= 12'd0;
            error_count_q <= 8'd0;
        end else begin
            cs_s1_q       <= cs_pin_i;
            cs_s2_q       <= cs_s1_q;
            cs_hist_q     <= cs_s2_q;
            sck_s1_q      <= clk_pin_i;
            sck_s2_q      <= sck_s1_q;
            sck_hist_q    <= sck_s2_q;
            dat_s1_q      <= data_pin_i;
            dat_s2_q      <= dat_s1_q;
            flushed_q     <= 1'b1;
            armed_q       <= armed_q | (flushed_q & cs_s1_q);
            state_q       <= state_d;
            count_q       <= count_d;
            shift_q       <= shift_d;
            strobe_q      <= strobe_d;
            frame_error_q <= frame_error_d;
            axis_q        <= axis_d;
            config_q      <= config_d;
            value_q       <= value_d;
            value_a_q     <= value_a_d;
            value_b_q     <= value_b_d;
            error_count_q <= error_count_d;
        end
    end

    assign strobe_o      = strobe_q;
    assign frame_error_o = frame_error_q;
    assign axis_o        = axis_q;
    assign config_o      = config_q;
    assign value_o       = value_q;
    assign value_a_o     = value_a_q;
    assign value_b_o     = value_b_q;
    assign error_count_o = error_count_q;

endmodule

// File: tb/tb_dac_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_rx
// Directed bench for dac_spi_rx. Two instances share the pins: index 0 has the
// config check disabled, index 1 has it enabled. A frame-level model predicts
// every output cycle by cycle; literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_dac_spi_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, cs_pin, clk_pin, data_pin;

    logic        strobe_w [2];
    logic        axis_w   [2];
    logic [2:0]  cfg_w    [2];
    logic [11:0] val_w    [2];
    logic [11:0] va_w     [2];
    logic [11:0] vb_w     [2];
    logic        ferr_w   [2];
    logic [7:0]  ec_w     [2];

    dac_spi_rx #(.CHECK_CONFIG(1'b0), .EXPECT_CONFIG(3'b111)) u_nochk (
        .clk_i(clk), .reset_i(reset), .cs_pin_i(cs_pin), .clk_pin_i(clk_pin),
        .data_pin_i(data_pin), .strobe_o(strobe_w[0]), .axis_o(axis_w[0]),
        .config_o(cfg_w[0]), .value_o(val_w[0]), .value_a_o(va_w[0]),
        .value_b_o(vb_w[0]), .frame_error_o(ferr_w[0]), .error_count_o(ec_w[0])
    );

    dac_spi_rx #(.CHECK_CONFIG(1'b1), .EXPECT_CONFIG(3'b111)) u_chk (
        .clk_i(clk), .reset_i(reset), .cs_pin_i(cs_pin), .clk_pin_i(clk_pin),
        .data_pin_i(data_pin), .strobe_o(strobe_w[1]), .axis_o(axis_w[1]),
        .config_o(cfg_w[1]), .value_o(val_w[1]), .value_a_o(va_w[1]),
        .value_b_o(vb_w[1]), .frame_error_o(ferr_w[1]), .error_count_o(ec_w[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model ----------------
    typedef struct {
        int          due;
        logic [15:0] frame;
        int          count;
    } ev_t;

    ev_t evq[$];

    logic        m_axis [2];
    logic [2:0]  m_cfg  [2];
    logic [11:0] m_val  [2];
    logic [11:0] m_va   [2];
    logic [11:0] m_vb   [2];
    int          m_ec   [2];
    int          n_strb [2];
    int          n_err  [2];

    bit          armed;
    bit          frame_open;
    logic [15:0] sh;
    int          cnt;

    task automatic model_clear();
        evq.delete();
        for (int i = 0; i < 2; i++) begin
            m_axis[i] = 1'b0; m_cfg[i] = 3'd0; m_val[i] = 12'd0;
            m_va[i] = 12'd0;  m_vb[i] = 12'd0; m_ec[i] = 0;
        end
        frame_open = 1'b0;
        armed      = 1'b0;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] cycle %0d: got %0h, expected %0h", name, idx, cyc, act, exp);
        end
    endtask

    // Cycle-by-cycle compare against the model.
    initial begin
        for (int i = 0; i < 2; i++) begin
            n_strb[i] = 0;
            n_err[i]  = 0;
        end
        forever begin
            bit exp_s [2];
            bit exp_e [2];
            @(posedge clk);
            #1;
            exp_s[0] = 1'b0; exp_s[1] = 1'b0; exp_e[0] = 1'b0; exp_e[1] = 1'b0;
            if (evq.size() > 0 && evq[0].due == cyc) begin
                ev_t ev;
                ev = evq.pop_front();
                for (int i = 0; i < 2; i++) begin
                    bit good;
                    good = (ev.count == 16) && ((i == 0) || (ev.frame[14:12] == 3'b111));
                    if (good) begin
                        exp_s[i]  = 1'b1;
                        m_axis[i] = ev.frame[15];
                        m_cfg[i]  = ev.frame[14:12];
                        m_val[i]  = ev.frame[11:0];
                        if (ev.frame[15]) m_vb[i] = ev.frame[11:0];
                        else              m_va[i] = ev.frame[11:0];
                    end else begin
                        exp_e[i] = 1'b1;
                        if (m_ec[i] < 255) m_ec[i] = m_ec[i] + 1;
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                chk("strobe", i, 32'(strobe_w[i]), 32'(exp_s[i]));
                chk("frame_error", i, 32'(ferr_w[i]), 32'(exp_e[i]));
                chk("axis", i, 32'(axis_w[i]), 32'(m_axis[i]));
                chk("config", i, 32'(cfg_w[i]), 32'(m_cfg[i]));
                chk("value", i, 32'(val_w[i]), 32'(m_val[i]));
                chk("value_a", i, 32'(va_w[i]), 32'(m_va[i]));
                chk("value_b", i, 32'(vb_w[i]), 32'(m_vb[i]));
                chk("error_count", i, 32'(ec_w[i]), m_ec[i]);
                if (strobe_w[i] === 1'b1) n_strb[i]++;
                if (ferr_w[i] === 1'b1)   n_err[i]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pin_cs(input logic v);
        cs_pin = v;
        if (v) begin
            if (frame_open) evq.push_back('{due: cyc + 3, frame: sh, count: cnt});
            frame_open = 1'b0;
            if (!reset) armed = 1'b1;
        end else if (armed) begin
            frame_open = 1'b1;
            sh  = 16'd0;
            cnt = 0;
        end
    endtask

    task automatic bit_in(input logic b);
        if (frame_open) begin
            sh  = {sh[14:0], b};
            cnt = (cnt < 17) ? cnt + 1 : 17;
        end
    endtask

    task automatic clk_bit(input logic b);
        clk_pin  = 1'b0;
        data_pin = b;
        tick();
        clk_pin = 1'b1;
        bit_in(b);
        tick();
    endtask

    // n bits of w, MSB first. co_start: first rise with CS fall;
    // co_end: an extra rise coincident with CS rise.
    task automatic send(input logic [16:0] w, input int n, input bit co_start, input bit co_end);
        int first;
        if (co_start) begin
            data_pin = w[n-1];
            tick();
            pin_cs(1'b0);
            clk_pin = 1'b1;
            bit_in(w[n-1]);
            tick();
            first = n - 2;
        end else begin
            pin_cs(1'b0);
            tick();
            first = n - 1;
        end
        for (int i = first; i >= 0; i--) clk_bit(w[i]);
        clk_pin = 1'b0;
        tick();
        if (co_end) begin
            clk_pin = 1'b1;
            pin_cs(1'b1);
            tick();
            clk_pin = 1'b0;
            tick();
        end else begin
            pin_cs(1'b1);
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        model_clear();
        repeat (n) tick();
        reset = 1'b0;
        armed = cs_pin;
    endtask

    int err_before;

    initial begin
        reset    = 1'b1;
        cs_pin   = 1'b1;
        clk_pin  = 1'b0;
        data_pin = 1'b0;
        armed    = 1'b0;
        frame_open = 1'b0;
        sh  = 16'd0;
        cnt = 0;

        do_reset(4);
        repeat (5) tick();
        chk("lit_reset_ec", 1, 32'(ec_w[1]), 32'd0);
        chk("lit_reset_va", 1, 32'(va_w[1]), 32'd0);

        // Single channel-B frame.
        send(17'h0F5A5, 16, 1'b0, 1'b0);
        repeat (6) tick();
        chk("lit_f5a5_vb", 1, 32'(vb_w[1]), 32'h5A5);
        chk("lit_f5a5_va", 1, 32'(va_w[1]), 32'h000);
        chk("lit_f5a5_axis", 1, 32'(axis_w[1]), 32'd1);
        chk("lit_f5a5_nstrb", 1, n_strb[1], 32'd1);

        // Back-to-back frames, one cycle of CS high between.
        send(17'h07123, 16, 1'b0, 1'b0);
        send(17'h0F456, 16, 1'b0, 1'b0);
        repeat (6) tick();
        chk("lit_b2b_va", 1, 32'(va_w[1]), 32'h123);
        chk("lit_b2b_vb", 1, 32'(vb_w[1]), 32'h456);
        chk("lit_b2b_nstrb", 1, n_strb[1], 32'd3);

        // 15-bit then 17-bit frames.
        send(17'h05555, 15, 1'b0, 1'b0);
        repeat (3) tick();
        send(17'h1F0F0, 17, 1'b0, 1'b0);
        repeat (6) tick();
        chk("lit_len_ec", 1, 32'(ec_w[1]), 32'd2);
        chk("lit_len_nerr", 1, n_err[1], 32'd2);
        chk("lit_len_nstrb", 1, n_strb[1], 32'd3);
        chk("lit_len_value", 1, 32'(val_w[1]), 32'h456);

        // Config mismatch: rejected with check, committed without.
        send(17'h03FFF, 16, 1'b0, 1'b0);
        repeat (6) tick();
        chk("lit_cfg_ec", 1, 32'(ec_w[1]), 32'd3);
        chk("lit_cfg_va_chk", 1, 32'(va_w[1]), 32'h123);
        chk("lit_cfg_va_nochk", 0, 32'(va_w[0]), 32'hFFF);
        chk("lit_cfg_cfg_nochk", 0, 32'(cfg_w[0]), 32'h3);

        // Coincident CS fall/clock rise and CS rise/clock rise.
        send(17'h07321, 16, 1'b1, 1'b1);
        repeat (6) tick();
        chk("lit_coinc_va", 1, 32'(va_w[1]), 32'h321);
        chk("lit_coinc_nstrb", 1, n_strb[1], 32'd4);

        // Reset after the 8th bit, released with CS low.
        pin_cs(1'b0);
        tick();
        for (int i = 15; i >= 8; i--) clk_bit(1'(16'h7ABC >> i));
        reset = 1'b1;
        model_clear();
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 7; i >= 5; i--) clk_bit(1'(16'h7ABC >> i));
        clk_pin = 1'b0;
        tick();
        err_before = n_err[1];
        pin_cs(1'b1);
        repeat (8) tick();
        chk("lit_rst_ec", 1, 32'(ec_w[1]), 32'd0);
        chk("lit_rst_nerr", 1, n_err[1], err_before);
        chk("lit_rst_va", 1, 32'(va_w[1]), 32'd0);
        send(17'h07ABC, 16, 1'b0, 1'b0);
        repeat (6) tick();
        chk("lit_rst_next_va", 1, 32'(va_w[1]), 32'hABC);

        // Error counter saturation.
        for (int k = 0; k < 300; k++) begin
            send(17'h00001, 1, 1'b0, 1'b0);
            tick();
        end
        repeat (6) tick();
        chk("lit_sat_ec", 1, 32'(ec_w[1]), 32'd255);
        chk("lit_sat_ec", 0, 32'(ec_w[0]), 32'd255);
        chk("lit_sat_va", 1, 32'(va_w[1]), 32'hABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dac_spi_rx.md
# dac_spi_rx

Receiving end of the DAC command link: decodes 16-bit SPI frames from the three DAC pins (active-low chip select, data sampled on the rising serial-clock edge, MSB first) back into channel/config/value fields. It exposes per-channel value registers and a one-cycle frame strobe. It serves as the loopback checker and bench monitor for the DAC driver, and as the input stage of a second board that consumes the vector stream. All pins are sampled in the `clk` domain; serial clock high and low phases must each be at least 1 `clk` cycle.

## Interface
- `CHECK_CONFIG`, 1: when 1, a frame whose config bits differ from `EXPECT_CONFIG` is an error.
- `EXPECT_CONFIG`, 3'b111: expected {buffered, gain, shutdown_n}.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cs_pin`  in  1  chip select, active low.
- `clk_pin`  in  1  serial clock.
- `data_pin`  in  1  serial data.
- `strobe`  out  1  one-cycle pulse: valid frame committed.
- `axis`  out  1  channel of the last valid frame (0=A, 1=B).
- `config`  out  3  {buffered, gain, shutdown_n} of the last valid frame.
- `value`  out  12  value of the last valid frame.
- `value_a` / `value_b`  out  12  last committed value per channel.
- `frame_error`  out  1  one-cycle pulse: frame rejected.
- `error_count`  out  8  saturating count of rejected frames.

## Operation
- Input stage: 2-flop synchronizer on each pin, plus one history flop on synced `cs` and synced `clk`. Synchronizer reset values: cs=1, clk=0, data=0.
- Edges are evaluated on synced signals: `cs_fall`, `cs_rise`, and `sck_rise` (synced clk 1, history 0).
- States:
  - IDLE: `sck_rise` ignored. `cs_fall` → ACTIVE, with bit count=0 and shift=0.
  - ACTIVE: on `sck_rise`, shift <= {shift[14:0], data}, and count increments, saturating at 17.
  - ACTIVE, on `cs_rise` → IDLE, then evaluate:
    - count==16, and the config check passes or `CHECK_CONFIG`=0 → commit.
    - otherwise → reject.
- Commit, from the 16-bit frame:
  - Decode: axis=bit15, config=bits14:12, value=bits11:0.
  - Update `axis`/`config`/`value`, plus `value_a` if axis=0 or `value_b` if axis=1.
  - Pulse `strobe`.
- Reject: no output register changes; pulse `frame_error`; `error_count` += 1, saturating at 255.
- Same-cycle `cs_fall` and `sck_rise`: the edge is captured as bit 0 (count=1).
- Same-cycle `cs_rise` and `sck_rise`: the edge is ignored; the frame is evaluated with the prior count.
- `strobe` and `frame_error` are never high together.
- Reset:
  - All outputs 0, state IDLE, count 0.
  - A frame in progress is dropped silently: no strobe, no error.
  - A frame whose `cs_fall` was missed (reset released while cs low) stays IDLE until the next `cs_fall`.

## Timing
- Pin-to-synced latency: 2 cycles. Edge detection is combinational on synced vs history.
- `strobe`/`frame_error` are high during the cycle after the edge where `cs_rise` is detected. That is 3 `clk` cycles after the first `clk` edge that samples `cs_pin` high.
- Output registers change in the same cycle `strobe` rises and hold until the next commit.
- Minimum accepted frame period: 16×2 cycles plus 4 cycles of CS high/low processing; back-to-back frames with 1 cycle of CS high are accepted.
- Data must be stable at the pins from at least 1 cycle before the clk_pin rise to 1 cycle after it. This matches a transmitter that changes data on the falling edge.

## Test plan
- Frame 0xF5A5 (axis=1, config=111, value=0x5A5) at clk/2 → one `strobe`; `value_b`=0x5A5; `value_a` unchanged at 0; `axis`=1.
- Frame 0x7123, then frame 0xF456 with 1 cycle of CS high between them → two strobes; `value_a`=0x123, `value_b`=0x456.
- 15-bit frame, then 17-bit frame → two `frame_error` pulses, `error_count`=2, no strobe, outputs unchanged.
- Frame 0x3FFF with `CHECK_CONFIG`=1 (config=011) → `frame_error`. Same frame with `CHECK_CONFIG`=0 → commit `value_a`=0xFFF.
- Reset asserted after the 8th bit, then released with cs still low, then CS rises → no strobe, no error, `error_count`=0. The next full frame 0x7ABC commits `value_a`=0xABC.
- 300 short frames → `error_count` saturates at 255.
